// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the FSM state type, RV32I load/store funct3 codes, RAM size codes
// and a small decode helper used when a request is accepted.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STORE = 3'd1,
        LOAD  = 3'd2,
        EXT   = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    // RV32I funct3 encodings for loads (stores reuse the B/H/W codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // RAM size codes
    localparam logic [2:0] MS_BYTE = 3'b000;
    localparam logic [2:0] MS_HALF = 3'b001;
    localparam logic [2:0] MS_WORD = 3'b010;

    // Unsigned loads exist only for byte and halfword; stores have no
    // unsigned variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extension.
// Purely combinational: turns the zero-extended word returned by the RAM
// into the architectural load result for the given funct3.
// Ports:
//   i_funct3 - RV32I load funct3
//   i_data   - raw RAM read data (already zero-extended by the RAM)
//   o_data   - sign/zero-extended load result
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_funct3)
            F3_B:    o_data = {{(DATA_W-8){i_data[7]}}, i_data[7:0]};
            F3_H:    o_data = {{(DATA_W-16){i_data[15]}}, i_data[15:0]};
            F3_BU:   o_data = {{(DATA_W-8){1'b0}}, i_data[7:0]};
            F3_HU:   o_data = {{(DATA_W-16){1'b0}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and the data RAM.
// Accepts one request at a time, computes ea = base + offset, decodes
// funct3 into a RAM size, checks alignment, drives one cycle of registered
// RAM strobes and returns a one-cycle response pulse.
// Ports:
//   clk, resetn            - clock, asynchronous active-low reset
//   req_*                  - request handshake and operands
//   rsp_valid/rdata/err    - one-cycle completion pulse and its payload
//   MemRead/MemWrite/MemSize/A_Ram/WriteData - registered RAM interface
//   ReadData               - RAM read data, valid the cycle after MemRead
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [2:0]        MemSize,
    output logic [ADDR_W-1:0] A_Ram,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    lsu_state_t        r_state;
    logic [2:0]        r_funct3;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [2:0]        r_mem_size;
    logic [ADDR_W-1:0] r_a_ram;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic [ADDR_W-1:0] w_ea;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_size;
    logic              w_misaligned;
    logic              w_err;
    logic              w_accept;
    logic [DATA_W-1:0] w_ext;

    assign w_ea = req_base + req_offset;

    always_comb begin
        w_size = MS_WORD;
        case (req_funct3[1:0])
            2'b00:   w_size = MS_BYTE;
            2'b01:   w_size = MS_HALF;
            default: w_size = MS_WORD;
        endcase
    end

    assign w_misaligned = ((w_size == MS_HALF) && w_ea[0]) ||
                          ((w_size == MS_WORD) && (w_ea[1:0] != 2'b00));
    assign w_err = !f3_legal(req_is_store, req_funct3) || w_misaligned;

    // The RAM picks the upper halfword with A_Ram[1:0] = 01 and rejects 10,
    // so ea[1] is moved down into bit 0 for halfword accesses.
    assign w_addr = (w_size == MS_HALF) ? {w_ea[ADDR_W-1:2], 1'b0, w_ea[1]} : w_ea;

    // Gated by resetn so ready is low while reset is held.
    assign req_ready = resetn && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;

    lsu_load_extend #(.DATA_W(DATA_W)) u_extend (
        .i_funct3 (r_funct3),
        .i_data   (ReadData),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_funct3    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_size  <= '0;
            r_a_ram     <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_a_ram    <= w_addr;
                            r_mem_size <= w_size;
                            if (req_is_store) begin
                                r_mem_write <= 1'b1;
                                r_wdata     <= req_wdata;
                                r_state     <= STORE;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= LOAD;
                            end
                        end
                    end
                end
                STORE: begin
                    r_mem_write <= 1'b0;
                    r_mem_size  <= '0;
                    r_a_ram     <= '0;
                    r_wdata     <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                LOAD: begin
                    r_mem_read <= 1'b0;
                    r_mem_size <= '0;
                    r_a_ram    <= '0;
                    r_state    <= EXT;
                end
                EXT: begin
                    r_rsp_rdata <= w_ext;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MemRead   = r_mem_read;
    assign MemWrite  = r_mem_write;
    assign MemSize   = r_mem_size;
    assign A_Ram     = r_a_ram;
    assign WriteData = r_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and the data RAM.
- Accepts one load or store request at a time and computes the effective address.
- Decodes RV32I funct3 into the RAM's size encoding and checks alignment.
- Drives registered RAM strobes, then returns sign- or zero-extended load data, or a store acknowledge, as a one-cycle response pulse.

Parameters:
- ADDR_W, 32, width of the address and RAM address bus
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  single system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request is accepted when req_valid && req_ready at a rising edge
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3
- req_base  in  32  rs1 value
- req_offset  in  32  sign-extended immediate
- req_wdata  in  32  rs2 value (store data)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3
- MemRead  out  1  RAM read strobe
- MemWrite  out  1  RAM write strobe
- MemSize  out  3  RAM size code: 000 byte, 001 halfword, 010 word
- A_Ram  out  32  RAM address
- WriteData  out  32  RAM write data
- ReadData  in  32  RAM read data; zero-extended by the RAM; registered on the edge where the RAM samples MemRead

Behaviour:
- Reset (asynchronous, active-low): the following take effect immediately.
  - state = IDLE.
  - All outputs are 0, except req_ready = 1 once resetn is deasserted.
  - Any in-flight access is abandoned. No response is produced for it, and MemWrite drops without waiting for a clock.
- Effective address: ea = req_base + req_offset, modulo 2^32, computed combinationally at acceptance.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is an error.
- Misalignment:
  - Halfword access with ea[0] = 1.
  - Word access with ea[1:0] != 00.
- RAM halfword encoding:
  - The RAM selects the upper half when A_Ram[1:0] = 01 and rejects offset 10.
  - For halfword accesses the unit therefore drives A_Ram = {ea[31:2], 1'b0, ea[1]}.
  - Byte and word accesses drive A_Ram = ea.
- WriteData = req_wdata unmodified; the RAM uses the low bits.
- All RAM-side outputs are registered. They are held stable for exactly one cycle per access.
- FSM states and transitions:
  - IDLE, on accept with an error: go to RESP. No strobes are asserted.
  - IDLE, on accept of a store: drive MemWrite = 1 with address, size and data; go to STORE.
  - IDLE, on accept of a load: drive MemRead = 1 with address and size; go to LOAD.
  - STORE: the RAM writes on this edge; MemWrite goes to 0; go to RESP.
  - LOAD: the RAM captures ReadData on this edge; MemRead goes to 0; go to EXT.
  - EXT:
    - Extend ReadData: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes through.
    - Register the result into rsp_rdata; go to RESP.
  - RESP: rsp_valid = 1 for one cycle; go to IDLE.
- Response contents:
  - rsp_rdata and rsp_err hold their value while rsp_valid = 1.
  - They clear to 0 on the next cycle.
- Latency, counted in cycles from the accept edge to the rsp_valid cycle:
  - Load: 3.
  - Store: 2.
  - Error: 1.
- Throughput:
  - There is no response backpressure; the core must consume rsp_valid when it occurs.
  - A new request can be accepted on the edge that leaves RESP only if req_ready is high. req_ready rises in IDLE, so back-to-back requests are spaced by their latency plus 1.
- req_valid while req_ready = 0 is ignored; the request is not queued.

Decomposition:
- Package lsu_pkg:
  - State enum: IDLE, STORE, LOAD, EXT, RESP.
  - funct3 localparams.
  - MemSize codes: MS_BYTE = 3'b000, MS_HALF = 3'b001, MS_WORD = 3'b010.
- One sub-module: lsu_load_extend, purely combinational. Inputs are funct3 and raw data; output is the extended data. Shared with future cache refill.

Test Plan:
- Byte loads: preload word 0x8899AABB at 0x100. LB ea=0x101 → MemRead one cycle, A_Ram=0x101, MemSize=000, rsp_rdata=0xFFFFFFAA, rsp_valid 3 cycles after accept. LBU at the same address → 0x000000AA.
- Halfword loads: LH with base 0x100, offset 2 → A_Ram=0x101, MemSize=001, rsp_rdata=0xFFFF8899. LHU ea=0x100 → A_Ram=0x100, rsp_rdata=0x0000AABB.
- Byte store: SB ea=0x102, wdata 0x12345677 → MemWrite one cycle, A_Ram=0x102, MemSize=000, WriteData=0x12345677. A following LW 0x100 → 0x8877AABB.
- Misaligned and illegal: SW ea=0x103 → MemWrite never asserted, rsp_valid 1 cycle after accept, rsp_err=1. Load with funct3=011 → rsp_err=1 and no MemRead.
- Address wrap: base 0xFFFFFFFC, offset 8 → A_Ram=0x00000004. Negative offset −4 with base 0x104 → A_Ram=0x100.
- Reset mid-load: assert resetn=0 while in LOAD → MemRead, rsp_valid and req_ready drop immediately with no response. After release, req_ready=1 and the next LW completes normally.
